// File: rtl/updown_counter_pkg.sv
// Shared constants and helpers for the up/down counter.
// Direction encodings and the load-value clamp used by updown_counter.
package updown_counter_pkg;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Values at or above the modulus are pinned to the top of the count range.
    function automatic logic [32:0] clamp_load(input logic [32:0] val, input logic [32:0] mod);
        return (val < mod) ? val : (mod - 33'd1);
    endfunction

endpackage

// File: rtl/updown_counter_next.sv
// Next-count arithmetic for updown_counter: one step up or down, wrap or saturate.
// UPDOWN_COUNTER_SAT_EN selects saturating limits instead of modular wrap.
module updown_counter_next
    import updown_counter_pkg::*;
#(
    parameter int              WIDTH = 16,
    parameter longint unsigned MOD   = 64'd1 << WIDTH,
    parameter int unsigned     STEP  = 1
) (
    input  logic [WIDTH-1:0] out,
    input  logic             dir,
    output logic [WIDTH-1:0] nxt,
    output logic             lim
);

    localparam int W1 = WIDTH + 1;
    localparam logic [WIDTH:0] MOD_W  = W1'(MOD);
    localparam logic [WIDTH:0] STEP_W = W1'(STEP);

    logic [WIDTH:0] cur_ext;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] res;

    assign cur_ext = {1'b0, out};
    assign sum     = cur_ext + STEP_W;

    always_comb begin
        res = sum;
        lim = 1'b0;
        if (dir == DIR_UP) begin
`ifdef UPDOWN_COUNTER_SAT_EN
            // Reaching the top counts as hitting the limit, not only overshooting it.
            lim = (sum >= MOD_W - W1'(1));
            res = (sum >= MOD_W) ? (MOD_W - W1'(1)) : sum;
`else
            lim = (sum >= MOD_W);
            res = lim ? (sum - MOD_W) : sum;
`endif
        end else begin
`ifdef UPDOWN_COUNTER_SAT_EN
            lim = (cur_ext <= STEP_W);
            res = (cur_ext < STEP_W) ? '0 : (cur_ext - STEP_W);
`else
            lim = (cur_ext < STEP_W);
            res = lim ? (cur_ext + MOD_W - STEP_W) : (cur_ext - STEP_W);
`endif
        end
    end

    assign nxt = res[WIDTH-1:0];

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down counter with clear, load, terminal-count and wrap pulse.
// Define UPDOWN_COUNTER_SAT_EN for saturating instead of modular counting.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int              WIDTH = 16,
    parameter longint unsigned MOD   = 64'd1 << WIDTH,
    parameter int unsigned     STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             zero,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 64'd1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] step_nxt;
    logic             step_lim;
    logic [WIDTH-1:0] load_clamped;

    updown_counter_next #(
        .WIDTH (WIDTH),
        .MOD   (MOD),
        .STEP  (STEP)
    ) u_next (
        .out (out_q),
        .dir (dir),
        .nxt (step_nxt),
        .lim (step_lim)
    );

    assign load_clamped = WIDTH'(clamp_load(33'(load_val), 33'(MOD)));

    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        if (zero) begin
            out_d = '0;
        end else if (load) begin
            out_d = load_clamped;
        end else if (en) begin
            out_d  = step_nxt;
            wrap_d = step_lim;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;
    assign tc   = (dir == DIR_UP) ? (out_q == MAX_VAL) : (out_q == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: a 16-bit full-range instance and a MOD=10, STEP=3 instance.
// Saturating-mode vectors are compiled in when UPDOWN_COUNTER_SAT_EN is defined.
module tb_updown_counter;

    logic        clk = 1'b0;
    logic        rst, en, dir, zero, load;
    logic [15:0] lv0;
    logic [3:0]  lv1;
    logic [15:0] out0;
    logic [3:0]  out1;
    logic        tc0, tc1, wrap0, wrap1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(16)) u0 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .zero(zero), .load(load),
        .load_val(lv0), .out(out0), .tc(tc0), .wrap(wrap0)
    );

    updown_counter #(.WIDTH(4), .MOD(10), .STEP(3)) u1 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .zero(zero), .load(load),
        .load_val(lv1), .out(out1), .tc(tc1), .wrap(wrap1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        int wraps;
        logic [3:0] exp_up[5];
        logic       exp_w[5];

        rst = 1'b1; en = 1'b0; dir = 1'b0; zero = 1'b0; load = 1'b0;
        lv0 = '0; lv1 = '0;

`ifndef UPDOWN_COUNTER_SAT_EN
        // Test 1: full-range 16-bit count up then down across zero
        tick();
        check("rst_out0", 32'(out0), 0);
        check("rst_wrap0", 32'(wrap0), 0);
        check("rst_tc0", 32'(tc0), 0);
        rst = 1'b0; en = 1'b1; dir = 1'b0;
        wraps = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (wrap0) wraps++;
        end
        check("up16_out0", 32'(out0), 16);
        check("up16_wraps", 32'(wraps), 0);
        dir = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (wrap0) wraps++;
            if (i == 16) check("dn_at_max", 32'(out0), 65535);
        end
        check("dn32_out0", 32'(out0), 65520);
        check("dn32_wraps", 32'(wraps), 1);

        // Test 2: MOD=10 STEP=3 up sequence and down wrap
        rst = 1'b1; en = 1'b0; tick();
        check("rst_out1", 32'(out1), 0);
        rst = 1'b0; en = 1'b1; dir = 1'b0;
        exp_up = '{4'd3, 4'd6, 4'd9, 4'd2, 4'd5};
        exp_w  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("m10_up%0d", i), 32'(out1), 32'(exp_up[i]));
            check($sformatf("m10_w%0d", i), 32'(wrap1), 32'(exp_w[i]));
        end
        en = 1'b0; load = 1'b1; lv1 = 4'd1; tick();
        check("m10_ld1", 32'(out1), 1);
        load = 1'b0; en = 1'b1; dir = 1'b1; tick();
        check("m10_dn_out", 32'(out1), 8);
        check("m10_dn_wrap", 32'(wrap1), 1);

        // Test 3: priority rst > zero > load > en, and load clamp
        rst = 1'b1; zero = 1'b1; load = 1'b1; en = 1'b1; dir = 1'b0; lv0 = 16'd7; lv1 = 4'd7;
        tick();
        check("pri_rst", 32'(out0), 0);
        rst = 1'b0; tick();
        check("pri_zero", 32'(out0), 0);
        check("pri_zero_w", 32'(wrap0), 0);
        zero = 1'b0; tick();
        check("pri_load", 32'(out0), 7);
        check("pri_load1", 32'(out1), 7);
        lv1 = 4'd15; tick();
        check("ld_clamp", 32'(out1), 9);
        check("ld_wrap", 32'(wrap1), 0);

        // Test 4: terminal count, combinational on dir, independent of en
        load = 1'b0; en = 1'b0; dir = 1'b0; #1;
        check("tc_up_max", 32'(tc1), 1);
        dir = 1'b1; #1;
        check("tc_dn_max", 32'(tc1), 0);
        load = 1'b1; lv1 = 4'd0; tick();
        load = 1'b0; #1;
        check("tc_dn_zero", 32'(tc1), 1);
        dir = 1'b0; #1;
        check("tc_up_zero", 32'(tc1), 0);

        // Test 6: mid-count reset then resume
        load = 1'b1; lv0 = 16'd1234; tick();
        load = 1'b0; en = 1'b1; dir = 1'b0; tick();
        check("mid_1235", 32'(out0), 1235);
        rst = 1'b1; tick();
        check("mid_rst_out", 32'(out0), 0);
        check("mid_rst_wrap", 32'(wrap0), 0);
        rst = 1'b0; tick();
        check("mid_step0", 32'(out0), 1);
        check("mid_step1", 32'(out1), 3);
`else
        // Test 5: saturating mode, MOD=10 STEP=3
        tick();
        check("sat_rst", 32'(out1), 0);
        rst = 1'b0; en = 1'b1; dir = 1'b0;
        exp_up = '{4'd3, 4'd6, 4'd9, 4'd9, 4'd9};
        exp_w  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sat_up%0d", i), 32'(out1), 32'(exp_up[i]));
            check($sformatf("sat_w%0d", i), 32'(wrap1), 32'(exp_w[i]));
        end
        en = 1'b0; load = 1'b1; lv1 = 4'd2; tick();
        check("sat_ld2", 32'(out1), 2);
        check("sat_ld_w", 32'(wrap1), 0);
        load = 1'b0; en = 1'b1; dir = 1'b1; tick();
        check("sat_dn_out", 32'(out1), 0);
        check("sat_dn_wrap", 32'(wrap1), 1);
        tick();
        check("sat_dn_hold", 32'(out1), 0);
        check("sat_dn_w2", 32'(wrap1), 1);
        en = 1'b0; tick();
        check("sat_idle_w", 32'(wrap1), 0);
        check("sat_tc", 32'(tc1), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
